// File: rtl/spike_window_decoder_pkg.sv
// Shared types and constants for the spike window decoder.
// FSM state encoding, default count ceiling and winner-index width helper.
package spike_dec_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_COUNT = 1'b1;

  localparam int DEF_CNT_W = 4;
  localparam int CNT_MAX   = (1 << DEF_CNT_W) - 1;

  function automatic int win_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/spike_window_decoder_if.sv
// Spike inputs plus the result valid/ready bus of the spike window decoder.
// master drives enable/spikes/ready; slave (the decoder) drives the result.
interface spike_window_decoder_if
  import spike_dec_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 4,
  parameter int WIN_W  = win_w(NUM_CH)
);
  logic                    en;
  logic [NUM_CH-1:0]       spike;
  logic                    out_ready;
  logic                    out_valid;
  logic [NUM_CH*CNT_W-1:0] counts;
  logic [WIN_W-1:0]        winner;
  logic                    winner_valid;
  logic                    overrun;

  modport master (
    output en, spike, out_ready,
    input  out_valid, counts, winner, winner_valid, overrun
  );

  modport slave (
    input  en, spike, out_ready,
    output out_valid, counts, winner, winner_valid, overrun
  );
endinterface

// File: rtl/spike_window_decoder_sat_counter.sv
// Per-channel saturating spike accumulator with synchronous clear (clear wins over inc).
// Latency: count reflects inc one cycle later; no backpressure.
module spike_sat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spike_window_decoder.sv
// Counts spikes per channel over WINDOW cycles, latches counts and winner at window end.
// Latency: result visible the cycle after the last window cycle; unconsumed results are overwritten (overrun).
module spike_window_decoder
  import spike_dec_pkg::*;
#(
  parameter int  NUM_CH = 2,
  parameter int  WINDOW = 16,
  parameter int  CNT_W  = 4,
  localparam int WIN_W  = win_w(NUM_CH)
) (
  input logic                   clk,
  input logic                   rst,
  spike_window_decoder_if.slave bus
);

  localparam int             WC_W    = $clog2(WINDOW);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW - 1);

  state_t                  state;
  logic [WC_W-1:0]         wcnt;
  logic                    counting;
  logic                    win_end;
  logic                    acc_clr;
  logic [CNT_W-1:0]        acc [NUM_CH];
  logic [CNT_W-1:0]        fin [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] fin_flat;
  logic [CNT_W-1:0]        best_val;
  logic [WIN_W-1:0]        best_idx;
  logic                    any_nz;

  logic [NUM_CH*CNT_W-1:0] counts_q;
  logic [WIN_W-1:0]        winner_q;
  logic                    winner_valid_q;
  logic                    out_valid_q;
  logic                    overrun_q;

  assign counting = (state == ST_COUNT);
  assign win_end  = counting && (wcnt == WC_LAST);
  assign acc_clr  = win_end || (counting && !bus.en);

  // fin folds in the current cycle's spike so the last window cycle is counted
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spike_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr),
      .inc (counting && bus.spike[g]),
      .cnt (acc[g])
    );
    assign fin[g] = (counting && bus.spike[g] && (acc[g] != '1)) ? acc[g] + CNT_W'(1) : acc[g];
  end

  // strict greater-than keeps ties on the lowest index
  always_comb begin
    fin_flat = '0;
    best_val = fin[0];
    best_idx = '0;
    any_nz   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      fin_flat[i*CNT_W +: CNT_W] = fin[i];
      if (fin[i] != '0) any_nz = 1'b1;
      if (fin[i] > best_val) begin
        best_val = fin[i];
        best_idx = WIN_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      wcnt  <= '0;
    end else if (!counting) begin
      if (bus.en) state <= ST_COUNT;
    end else begin
      if (!bus.en) state <= ST_IDLE;
      if (win_end || !bus.en) wcnt <= '0;
      else                    wcnt <= wcnt + WC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counts_q       <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      out_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else if (win_end) begin
      counts_q       <= fin_flat;
      winner_q       <= best_idx;
      winner_valid_q <= any_nz;
      out_valid_q    <= 1'b1;
      if (out_valid_q && !bus.out_ready) overrun_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.counts       = counts_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.overrun      = overrun_q;

endmodule
